spike_isi_monitor: RTL and testbench
====================================

Name: spike_isi_monitor

Overview:
- Downstream stage of the Izhikevich neuron core: consumes the core's 1-cycle spike pulse and its neuron-update strobe.
- Measures the inter-spike interval (ISI) in neuron time steps and buffers the ISIs in a small FIFO.
- Presents the ISIs on a valid/ready byte interface that the top-level wrapper maps onto output pins.

Parameters:
- ISI_W, 8, ISI counter and data width in bits; the counter saturates at 2^ISI_W-1.
- FIFO_DEPTH, 4, number of buffered ISI entries; must be a power of two and at least 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear: empties the FIFO, zeroes the counter, clears overflow, returns to IDLE.
- step_en, input, 1, neuron time-step strobe from the core (one pulse per membrane update).
- spike, input, 1, 1-cycle spike pulse from the core.
- out_data, output, ISI_W, ISI at the FIFO head; 0 when the FIFO is empty.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, consumer accept; an entry pops when out_valid and out_ready are both high.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow, output, 1, sticky flag: an ISI was dropped because the FIFO was full.
- armed, output, 1, high in the ARMED state.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, cnt=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0, armed=0.
- FSM states:
  - IDLE: no reference spike yet. On spike: go to ARMED, cnt<=0, no push.
  - ARMED: each step_en increments cnt, saturating at 2^ISI_W-1.
    - On spike: push isi = (step_en ? sat(cnt+1) : cnt), then cnt<=0.
    - The ISI therefore counts step_en pulses after the previous spike cycle, up to and including the current spike cycle.
    - Stay in ARMED.
- clear takes priority over spike, step_en and pop in the same cycle; the next state is IDLE.
- Push/pop latency: a push at cycle N shows at the FIFO head at N+1 if the FIFO was empty (out_valid rises at N+1). A pop at N presents the next entry at N+1.
- FIFO ordering: first in, first out.
- Full FIFO, push without pop: ISI is dropped, overflow<=1 (sticky until clear or reset), fifo_level stays FIFO_DEPTH.
- Full FIFO, push with pop in the same cycle: both happen, level unchanged, no overflow.
- Empty FIFO, pop attempted: impossible because out_valid=0; no state change.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is tracked explicitly, so full and empty are unambiguous.
- A spike pulse is always exactly one cycle; consecutive-cycle spikes are treated as separate spikes, giving an ISI of 0 or 1 depending on step_en.
- rst_n asserted mid-operation: immediate return to reset values; buffered data is lost.

Optional Feature:
- Macro: SPIKE_TOTAL_CNT_EN.
- Defined: adds output spike_total [15:0].
  - Counts every spike pulse, including the arming spike in IDLE.
  - Wraps at 65535->0.
  - Cleared by clear and by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package izh_monitor_pkg:
  - ISI_W_DEFAULT=8 and FIFO_DEPTH_DEFAULT=4 localparams.
  - FSM state typedef {IDLE, ARMED}.
- One natural sub-module, isi_fifo: synchronous FIFO with push/pop, level, full/empty outputs and a clear input.
- spike_isi_monitor contains the FSM, the saturating counter, overflow logic and the isi_fifo instance.

Test Plan:
- Basic ISI: reset, step_en=1 every cycle, spike at cycles 5 and 15, out_ready=0 -> no push at 5. Push of 10 at 15; out_valid=1 at 16, out_data=10, fifo_level=1.
- Saturation: ISI_W=8, 300 step_en pulses between spikes -> out_data=255, no wrap.
- Overflow: out_ready=0, six ISIs of 3,4,5,6,7,8 -> fifo_level=4, overflow=1. Popping yields 3,4,5,6 then out_valid=0. Pulse clear -> overflow=0, armed=0.
- Full push+pop: FIFO full, spike with ISI 9 and out_ready=1 in the same cycle -> level stays 4, overflow=0, 9 is the last entry popped.
- Boundaries:
  - spike with step_en=0 after cnt=7 -> ISI 7.
  - spike with step_en=1 after cnt=7 -> ISI 8.
  - clear and spike in the same cycle -> IDLE, no push.
  - rst_n pulsed mid-count -> all outputs return to zero immediately.
- SPIKE_TOTAL_CNT_EN: 70000 spikes -> spike_total=4464; clear -> 0.

Source files
------------

// File: rtl/izh_monitor_pkg.sv
// Shared definitions for the Izhikevich spike ISI monitor: default sizes and FSM state type.
package izh_monitor_pkg;

  localparam int ISI_W_DEFAULT      = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } mon_state_t;

endpackage

// File: rtl/isi_fifo.sv
// Synchronous FIFO for ISI samples: explicit level counter, combinational head read, clear input.
module isi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == LVL_W'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff = push && (!full || pop_eff);
  assign level    = level_reg;
  assign dout     = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage needs no reset: stale entries are never visible while the level says empty.
  always_ff @(posedge clk) begin
    if (!clear && push_eff) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_eff && !pop_eff)      level_reg <= level_reg + 1'b1;
      else if (pop_eff && !push_eff) level_reg <= level_reg - 1'b1;
    end
  end

endmodule

// File: rtl/spike_isi_monitor.sv
// Inter-spike interval monitor: counts step_en pulses between spikes and queues ISIs for a byte consumer.
// Optional SPIKE_TOTAL_CNT_EN adds a 16-bit wrapping count of all spike pulses.
module spike_isi_monitor
  import izh_monitor_pkg::*;
#(
  parameter int ISI_W      = ISI_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          step_en,
  input  logic                          spike,
  output logic [ISI_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          armed
`ifdef SPIKE_TOTAL_CNT_EN
  ,
  output logic [15:0]                   spike_total
`endif
);

  localparam logic [ISI_W-1:0] CNT_MAX = '1;

  mon_state_t       state_reg;
  logic [ISI_W-1:0] cnt_reg;
  logic [ISI_W-1:0] cnt_inc;
  logic [ISI_W-1:0] isi_value;
  logic             overflow_reg;
  logic             push_req;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;

  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  // The spike cycle's own step pulse belongs to the interval that ends here.
  assign isi_value = step_en ? cnt_inc : cnt_reg;
  assign push_req  = !clear && spike && (state_reg == ARMED);
  assign pop_req   = !fifo_empty && out_ready;

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_reg;
  assign armed     = (state_reg == ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (spike) begin
            state_reg <= ARMED;
            cnt_reg   <= '0;
          end
        end
        ARMED: begin
          if (spike)        cnt_reg <= '0;
          else if (step_en) cnt_reg <= cnt_inc;
        end
        default: state_reg <= IDLE;
      endcase
      if (push_req && fifo_full && !pop_req) overflow_reg <= 1'b1;
    end
  end

`ifdef SPIKE_TOTAL_CNT_EN
  logic [15:0] total_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      total_reg <= '0;
    else if (clear)  total_reg <= '0;
    else if (spike)  total_reg <= total_reg + 16'd1;
  end

  assign spike_total = total_reg;
`endif

  isi_fifo #(
    .W     (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_req),
    .pop   (pop_req),
    .din   (isi_value),
    .dout  (out_data),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spike_isi_monitor.sv
// Randomized and directed bench for spike_isi_monitor against a queue-based ISI model.
// Define SPIKE_TOTAL_CNT_EN to also exercise the spike_total counter.
module tb_spike_isi_monitor;

  localparam int ISI_W  = 8;
  localparam int DEPTH  = 4;
  localparam int SATMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       step_en = 1'b0;
  logic       spike = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       armed;
`ifdef SPIKE_TOTAL_CNT_EN
  logic [15:0] spike_total;
`endif

  spike_isi_monitor #(.ISI_W(ISI_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .step_en    (step_en),
    .spike      (spike),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .armed      (armed)
`ifdef SPIKE_TOTAL_CNT_EN
    ,
    .spike_total(spike_total)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: ISIs as plain step counts since the last spike
  bit      m_armed;
  int      m_steps;
  int      m_q[$];
  bit      m_ovf;
  int      m_total;
  int      popped[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else passed++;
  endtask

  function automatic void model_reset();
    m_armed = 0;
    m_steps = 0;
    m_q.delete();
    m_ovf   = 0;
    m_total = 0;
  endfunction

  function automatic void model_cycle(bit c, bit s, bit st, bit rdy);
    int isi;
    if (c) begin
      model_reset();
      return;
    end
    if (s) m_total = (m_total + 1) % 65536;
    if (rdy && m_q.size() > 0) popped.push_back(m_q.pop_front());
    if (!m_armed) begin
      if (s) begin
        m_armed = 1;
        m_steps = 0;
      end
    end else begin
      isi = m_steps + (st ? 1 : 0);
      if (isi > SATMAX) isi = SATMAX;
      if (s) begin
        if (m_q.size() < DEPTH) m_q.push_back(isi);
        else m_ovf = 1;
        m_steps = 0;
      end else begin
        m_steps = isi;
      end
    end
  endfunction

  task automatic compare_all();
    check("valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("data",  32'(out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("level", 32'(fifo_level), 32'(m_q.size()));
    check("ovf",   32'(overflow),  32'(m_ovf));
    check("armed", 32'(armed),     32'(m_armed));
  endtask

  task automatic cycle(input bit c, input bit s, input bit st, input bit rdy, input bit verbose);
    @(negedge clk);
    clear = c; spike = s; step_en = st; out_ready = rdy;
    model_cycle(c, s, st, rdy);
    @(posedge clk);
    #1;
    if (verbose && s && !c)
      $display("spike: step_en=%0b ready=%0b -> level=%0d head=%0d ovf=%0b",
               st, rdy, fifo_level, out_data, overflow);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0);
  endtask

  task automatic drain();
    int budget = 20;
    while (m_q.size() > 0 && budget > 0) begin
      cycle(0, 0, 0, 1, 0);
      budget--;
    end
    check("drain_done", 32'(out_valid), 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    check("reset_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ISI: arming spike, then 10 steps up to and including the next spike
    cycle(0, 1, 1, 0, 1);
    steps(9);
    cycle(0, 1, 1, 0, 1);
    check("basic_isi", 32'(out_data), 32'd10);
    check("basic_lvl", 32'(fifo_level), 32'd1);
    drain();

    // Saturation
    steps(300);
    cycle(0, 1, 0, 0, 1);
    check("sat_isi", 32'(out_data), 32'd255);
    drain();

    // Overflow: ISIs 3..8 into a 4-deep FIFO
    for (int n = 3; n <= 8; n++) begin
      steps(n);
      cycle(0, 1, 0, 0, 1);
    end
    check("ovf_lvl", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    popped.delete();
    drain();
    check("ovf_pop_n", 32'(popped.size()), 32'd4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      check("ovf_pop_val", 32'(popped[i]), 32'(i + 3));
    cycle(1, 0, 0, 0, 1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_armed", 32'(armed), 32'd0);

    // Full FIFO with simultaneous push and pop
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      steps(1);
      cycle(0, 1, 0, 0, 1);
    end
    steps(8);
    cycle(0, 1, 1, 1, 1);
    check("fpp_lvl", 32'(fifo_level), 32'd4);
    check("fpp_ovf", 32'(overflow), 32'd0);
    popped.delete();
    drain();
    if (popped.size() > 0) check("fpp_last", 32'(popped[popped.size()-1]), 32'd9);
    else check("fpp_last_missing", 32'd0, 32'd1);

    // Boundaries around cnt=7
    steps(7);
    cycle(0, 1, 0, 0, 1);
    check("b_isi7", 32'(out_data), 32'd7);
    drain();
    steps(7);
    cycle(0, 1, 1, 0, 1);
    check("b_isi8", 32'(out_data), 32'd8);
    cycle(1, 1, 1, 0, 1);
    check("clr_spk_armed", 32'(armed), 32'd0);
    check("clr_spk_lvl", 32'(fifo_level), 32'd0);

    // Asynchronous reset mid-count
    cycle(0, 1, 0, 0, 1);
    steps(5);
    cycle(0, 1, 1, 0, 1);
    steps(3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0), 0);
    end

`ifdef SPIKE_TOTAL_CNT_EN
    cycle(1, 0, 0, 0, 1);
    check("tot_clr", 32'(spike_total), 32'd0);
    for (int i = 0; i < 70000; i++) cycle(0, 1, 0, 1, 0);
    check("tot_wrap", 32'(spike_total), 32'd4464);
    check("tot_model", 32'(spike_total), 32'(m_total));
    cycle(1, 0, 0, 0, 1);
    check("tot_clr2", 32'(spike_total), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
